multicycle_control: RTL

Main control FSM for the multi-cycle MIPS core. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. In each state it drives the execute stage (ALUOp, ALU source selects, RegDst), the register file, the PC and the shared instruction/data memory. Memory accesses use a ready handshake, so slow memory stretches the sequence without corrupting it.

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/ctrl_opcode_decode.sv | 29 ++
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes
// and the ALU / mux select codes that the datapath and ALU control also import.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_I_EXEC    = 4'd10,
        ST_I_WB      = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ITYPE,
        CLS_ILLEGAL
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier: instruction class, I-type ALU operation
// and a legal flag for the main control FSM.
module ctrl_opcode_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    output instr_class_e cls,
    output logic [2:0]   i_alu_op,
    output logic         legal
);

    always_comb begin
        cls      = CLS_ILLEGAL;
        i_alu_op = ALU_ADD;
        unique case (opcode)
            OP_RTYPE:     cls = CLS_RTYPE;
            OP_LW, OP_SW: cls = CLS_MEM;
            OP_BEQ:       cls = CLS_BRANCH;
            OP_J:         cls = CLS_JUMP;
            OP_ADDI: begin cls = CLS_ITYPE; i_alu_op = ALU_ADD; end
            OP_ANDI: begin cls = CLS_ITYPE; i_alu_op = ALU_AND; end
            OP_ORI:  begin cls = CLS_ITYPE; i_alu_op = ALU_OR;  end
            OP_SLTI: begin cls = CLS_ITYPE; i_alu_op = ALU_SLT; end
            default:      cls = CLS_ILLEGAL;
        endcase
        legal = (cls != CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode,
// execute, memory and write-back, stalling on the memory ready handshake.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e       state_q, state_d;
    logic [5:0]   opcode_q, opcode_d;
    logic [5:0]   dec_opcode;
    instr_class_e dec_cls;
    logic [2:0]   dec_i_alu_op;
    logic         dec_legal;

    // One decoder serves both uses: live opcode in DECODE, latched opcode after.
    assign dec_opcode = (state_q == ST_DECODE) ? opcode : opcode_q;
    assign opcode_d   = (state_q == ST_DECODE) ? opcode : opcode_q;

    ctrl_opcode_decode u_decode (
        .opcode   (dec_opcode),
        .cls      (dec_cls),
        .i_alu_op (dec_i_alu_op),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                unique case (dec_cls)
                    CLS_RTYPE:  state_d = ST_R_EXEC;
                    CLS_MEM:    state_d = ST_MEM_ADDR;
                    CLS_BRANCH: state_d = ST_BRANCH;
                    CLS_JUMP:   state_d = ST_JUMP;
                    CLS_ITYPE:  state_d = ST_I_EXEC;
                    default:    state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR:  state_d = (opcode_q == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_R_WB:      state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_JUMP:      state_d = ST_FETCH;
            ST_I_EXEC:    state_d = ST_I_WB;
            ST_I_WB:      state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        state         = state_q;
        unique case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b  = SRCB_IMM_SL2;
                illegal_op = !dec_legal;
                instr_done = !dec_legal;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = dec_i_alu_op;
            end
            ST_I_WB: begin
                reg_write  = 1'b1;
                alu_op     = dec_i_alu_op;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides everything so an abandoned access issues no writes.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = '0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = '0;
            alu_op        = '0;
            instr_done    = 1'b0;
            illegal_op    = 1'b0;
            state         = '0;
        end
    end

endmodule
